// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter onto a single shared data bus; one transfer in flight at a time.
// Optional slave-stall abort is compiled in with `define DBUS_ARB_TIMEOUT_EN.
module dbus_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic        m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_wen,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        m_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  grant_q, grant_d;
    logic        owner_valid;
    logic        stall;
    logic        timeout;

    assign owner_valid = ((state_q == GNT0) && m0_valid) || ((state_q == GNT1) && m1_valid);
    assign stall       = owner_valid && !s_ready;

`ifdef DBUS_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Fires on the stall cycle that would bring the count up to TIMEOUT_CYCLES.
    assign timeout = stall && (cnt_q == (TIMEOUT_CYCLES - 16'd1));
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    assign m_err = timeout;
    assign grant = grant_q;

    always_comb begin
        s_valid  = 1'b0;
        s_wen    = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        case (state_q)
            GNT0: begin
                s_valid  = m0_valid && !timeout;
                s_wen    = m0_wen;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = m0_valid && (s_ready || timeout);
                m0_rdata = (m0_valid && s_ready) ? s_rdata : '0;
            end
            GNT1: begin
                s_valid  = m1_valid && !timeout;
                s_wen    = m1_wen;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = m1_valid && (s_ready || timeout);
                m1_rdata = (m1_valid && s_ready) ? s_rdata : '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
`ifdef DBUS_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // last_grant_q=1 means m1 was served last, so m0 wins a tie.
                if (m0_valid && (!m1_valid || last_grant_q)) begin
                    state_d = GNT0;
                    grant_d = 2'b01;
`ifdef DBUS_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (m1_valid) begin
                    state_d = GNT1;
                    grant_d = 2'b10;
`ifdef DBUS_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GNT0, GNT1: begin
                if (!owner_valid) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else if (s_ready || timeout) begin
                    state_d      = IDLE;
                    grant_d      = 2'b00;
                    last_grant_d = (state_q == GNT1);
                end else begin
`ifdef DBUS_ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
`ifdef DBUS_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
`ifdef DBUS_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: completions go through a scoreboard queue checked by a
// negedge monitor; bus-side fields and grant are checked directly by the stimulus thread.
module tb_dbus_arbiter;

    typedef struct packed {
        logic        mst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        m0_valid, m0_wen, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_wen, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_wen, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        m_err;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    dbus_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .m_err(m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic mst, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.mst   = mst;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_wen = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_wen = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Completion monitor: every ready pulse must match the oldest expected transfer.
    always @(negedge clk) begin
        exp_t e;
        chk("ready_onehot", 32'(m0_ready && m1_ready), 32'd0);
        if (!m0_ready) chk("m0_rdata_idle", m0_rdata, 32'd0);
        if (!m1_ready) chk("m1_rdata_idle", m1_rdata, 32'd0);
        if (!m0_ready && !m1_ready) chk("m_err_idle", 32'(m_err), 32'd0);
        if (m0_ready || m1_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 32'(m1_ready), 32'(!m1_ready));
            end else begin
                e = exp_q.pop_front();
                chk("done_master", 32'(m1_ready), 32'(e.mst));
                chk("done_rdata", e.mst ? m1_rdata : m0_rdata, e.rdata);
                chk("done_err", 32'(m_err), 32'(e.err));
            end
        end
    end

    initial begin
        do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wstrb", 32'(s_wstrb), 32'd0);
        chk("rst_m_err", 32'(m_err), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single m0 read
        tick();
        m0_valid = 1'b1; m0_wen = 1'b0; m0_addr = 32'h1000_0000;
        s_ready = 1'b1; s_rdata = 32'h0000_00A5;
        push(1'b0, 32'h0000_00A5, 1'b0);
        #2;
        chk("t1_idle_grant", 32'(grant), 32'd0);
        chk("t1_idle_s_valid", 32'(s_valid), 32'd0);
        tick();
        #2;
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_s_valid", 32'(s_valid), 32'd1);
        chk("t1_s_addr", s_addr, 32'h1000_0000);
        chk("t1_s_wen", 32'(s_wen), 32'd0);
        tick();
        m0_valid = 1'b0;
        #2;
        chk("t1_back_idle", 32'(grant), 32'd0);

        // Simultaneous requests after reset, then round-robin
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        s_ready = 1'b1; s_rdata = 32'h11;
        push(1'b0, 32'h11, 1'b0);
        #2;
        tick();
        #2;
        chk("t2_first_grant", 32'(grant), 32'h1);
        chk("t2_first_addr", s_addr, 32'h0000_0100);
        tick();
        m0_addr = 32'h0000_0104; s_rdata = 32'h22;
        push(1'b1, 32'h22, 1'b0);
        #2;
        chk("t2_gap_grant", 32'(grant), 32'd0);
        tick();
        #2;
        chk("t2_rr_grant", 32'(grant), 32'h2);
        chk("t2_rr_addr", s_addr, 32'h0000_0200);
        tick();
        m1_valid = 1'b0; s_rdata = 32'h33;
        push(1'b0, 32'h33, 1'b0);
        #2;
        tick();
        #2;
        chk("t2_third_grant", 32'(grant), 32'h1);
        chk("t2_third_addr", s_addr, 32'h0000_0104);
        tick();
        m0_valid = 1'b0;

        // m1 write stalled five cycles while m0 waits
        m1_valid = 1'b1; m1_wen = 1'b1; m1_addr = 32'h2000_0004;
        m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
        s_ready = 1'b0; s_rdata = 32'hCAFE_0001;
        push(1'b1, 32'hCAFE_0001, 1'b0);
        #2;
        tick();
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) begin
                m0_valid = 1'b1; m0_wen = 1'b0; m0_addr = 32'h0000_3000;
                push(1'b0, 32'h77, 1'b0);
            end
            if (k == 6) s_ready = 1'b1;
            #2;
            chk("t3_grant", 32'(grant), 32'h2);
            chk("t3_s_valid", 32'(s_valid), 32'd1);
            chk("t3_s_wen", 32'(s_wen), 32'd1);
            chk("t3_s_addr", s_addr, 32'h2000_0004);
            chk("t3_s_wdata", s_wdata, 32'h1234_5678);
            chk("t3_s_wstrb", 32'(s_wstrb), 32'h3);
            tick();
        end
        m1_valid = 1'b0; m1_wen = 1'b0; s_rdata = 32'h77;
        #2;
        chk("t3_gap_grant", 32'(grant), 32'd0);
        tick();
        #2;
        chk("t3_m0_grant", 32'(grant), 32'h1);
        chk("t3_m0_addr", s_addr, 32'h0000_3000);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;

        // m1 withdraws; last_grant (m0) must be unchanged so m1 wins the next tie
        m1_valid = 1'b1; m1_addr = 32'h0000_0050;
        #2;
        tick();
        #2;
        chk("t4_grant", 32'(grant), 32'h2);
        m1_valid = 1'b0;
        #1;
        chk("t4_withdraw_s_valid", 32'(s_valid), 32'd0);
        tick();
        #2;
        chk("t4_withdraw_idle", 32'(grant), 32'd0);
        m0_valid = 1'b1; m0_addr = 32'h0000_0060;
        m1_valid = 1'b1; m1_addr = 32'h0000_0064;
        s_ready = 1'b1; s_rdata = 32'h44;
        push(1'b1, 32'h44, 1'b0);
        tick();
        #2;
        chk("t4_tie_grant", 32'(grant), 32'h2);
        chk("t4_tie_addr", s_addr, 32'h0000_0064);
        tick();
        m1_valid = 1'b0; s_rdata = 32'h45;
        push(1'b0, 32'h45, 1'b0);
        tick();
        #2;
        chk("t4_m0_grant", 32'(grant), 32'h1);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;

        // Asynchronous reset in the middle of a stalled m0 transfer
        m0_valid = 1'b1; m0_addr = 32'h0000_0070;
        #2;
        tick();
        #2;
        chk("t5_grant", 32'(grant), 32'h1);
        chk("t5_s_valid", 32'(s_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_s_valid", 32'(s_valid), 32'd0);
        chk("t5_async_grant", 32'(grant), 32'd0);
        chk("t5_async_s_addr", s_addr, 32'd0);
        m0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0000_0080;
        m1_valid = 1'b1; m1_addr = 32'h0000_0084;
        s_ready = 1'b1; s_rdata = 32'h55;
        push(1'b0, 32'h55, 1'b0);
        #2;
        tick();
        #2;
        chk("t5_post_grant", 32'(grant), 32'h1);
        chk("t5_post_addr", s_addr, 32'h0000_0080);
        tick();
        m0_valid = 1'b0; s_rdata = 32'h56;
        push(1'b1, 32'h56, 1'b0);
        tick();
        #2;
        chk("t5_post_m1_grant", 32'(grant), 32'h2);
        tick();
        m1_valid = 1'b0; s_ready = 1'b0;

`ifdef DBUS_ARB_TIMEOUT_EN
        // Timeout abort on the 8th stall cycle, then completion winning on that same cycle
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0090;
        s_rdata = 32'h0000_0BAD;
        push(1'b0, 32'h0, 1'b1);
        #2;
        tick();
        for (int k = 1; k <= 8; k++) begin
            #2;
            chk("t6_s_valid", 32'(s_valid), (k == 8) ? 32'd0 : 32'd1);
            chk("t6_m_err", 32'(m_err), (k == 8) ? 32'd1 : 32'd0);
            chk("t6_m0_ready", 32'(m0_ready), (k == 8) ? 32'd1 : 32'd0);
            tick();
        end
        m0_valid = 1'b0;
        #2;
        chk("t6_after_grant", 32'(grant), 32'd0);
        m0_valid = 1'b1; m0_addr = 32'h0000_0094; s_rdata = 32'h99;
        push(1'b0, 32'h99, 1'b0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) s_ready = 1'b1;
            #2;
            chk("t7_m_err", 32'(m_err), 32'd0);
            chk("t7_s_valid", 32'(s_valid), 32'd1);
            tick();
        end
        m0_valid = 1'b0; s_ready = 1'b0;
`endif

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
